// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
// Macro ALU_SEQ_DIV_EN (used by alu_seq and alu_seq_muldiv) enables the DIVU datapath.
package alu_seq_pkg;

    localparam logic [3:0] ALU_OP_AND  = 4'b0000;
    localparam logic [3:0] ALU_OP_OR   = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
    localparam logic [3:0] ALU_OP_SRA  = 4'b0011;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0100;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
    localparam logic [3:0] ALU_OP_MULU = 4'b1000;
    localparam logic [3:0] ALU_OP_DIVU = 4'b1001;
    localparam logic [3:0] ALU_OP_XOR  = 4'b1010;
    localparam logic [3:0] ALU_OP_NOR  = 4'b1011;
    localparam logic [3:0] ALU_OP_SLTU = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// Divider datapath present only when ALU_SEQ_DIV_EN is defined; o_hi/o_lo carry the next-step values.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_DIV_EN
    input  logic             i_is_div,
`endif
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;
`ifdef ALU_SEQ_DIV_EN
    logic             r_is_div;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
`endif

    // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
    // Divide: {hi,lo} holds remainder and dividend, quotient bits shift into lo.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_hi_nxt  = w_mul_sum[WIDTH:1];
        w_lo_nxt  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
        if (r_is_div) begin
            w_hi_nxt = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (i_start) begin
            r_hi   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= i_is_div;
            r_lo     <= i_is_div ? i_a : i_b;
            r_opnd   <= i_is_div ? i_b : i_a;
`else
            r_lo   <= i_b;
            r_opnd <= i_a;
`endif
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end

    assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle ops, iterative MULU/DIVU, valid/ready on both sides.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU reports illegal_op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_y, r_y_hi;
    logic             r_zero, r_ill;
    logic             w_accept, w_use_eng, w_eng_done, w_one_ill;
    logic [WIDTH-1:0] w_one_y, w_one_hi, w_eng_hi, w_eng_lo;
    logic [SHW-1:0]   w_shamt;
`ifdef ALU_SEQ_DIV_EN
    logic             r_dbz, w_one_dbz, w_is_div;
`endif

    assign w_shamt   = b[SHW-1:0];
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_one_y   = '0;
        w_one_hi  = '0;
        w_one_ill = 1'b0;
        w_use_eng = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        w_one_dbz = 1'b0;
`endif
        case (op)
            ALU_OP_AND:  w_one_y = a & b;
            ALU_OP_OR:   w_one_y = a | b;
            ALU_OP_ADD:  w_one_y = a + b;
            ALU_OP_SRA:  w_one_y = $signed(a) >>> w_shamt;
            ALU_OP_SLL:  w_one_y = a << w_shamt;
            ALU_OP_SRL:  w_one_y = a >> w_shamt;
            ALU_OP_SUB:  w_one_y = a - b;
            ALU_OP_SLT:  w_one_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_XOR:  w_one_y = a ^ b;
            ALU_OP_NOR:  w_one_y = ~(a | b);
            ALU_OP_SLTU: w_one_y = {{(WIDTH-1){1'b0}}, a < b};
            ALU_OP_MULU: w_use_eng = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            ALU_OP_DIVU: begin
                if (b == '0) begin
                    w_one_y   = '1;
                    w_one_hi  = a;
                    w_one_dbz = 1'b1;
                end else begin
                    w_use_eng = 1'b1;
                end
            end
`endif
            default:     w_one_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    assign w_is_div = (op == ALU_OP_DIVU);
`endif

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ALU_SEQ_DIV_EN
        .i_is_div (w_is_div),
`endif
        .i_start  (w_accept && w_use_eng),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_eng_done),
        .o_hi     (w_eng_hi),
        .o_lo     (w_eng_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = w_use_eng ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_eng_done) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Results stay in these registers through DONE; flags are cleared when a multi-cycle op starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_y_hi <= '0;
            r_zero <= 1'b0;
            r_ill  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_dbz  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_zero <= w_use_eng ? 1'b0 : (w_one_y == '0);
            r_ill  <= w_use_eng ? 1'b0 : w_one_ill;
`ifdef ALU_SEQ_DIV_EN
            r_dbz  <= w_use_eng ? 1'b0 : w_one_dbz;
`endif
            if (!w_use_eng) begin
                r_y    <= w_one_y;
                r_y_hi <= w_one_hi;
            end
        end else if (r_state == ST_EXEC && w_eng_done) begin
            r_y    <= w_eng_lo;
            r_y_hi <= w_eng_hi;
            r_zero <= (w_eng_lo == '0);
        end
    end

    assign y          = r_y;
    assign y_hi       = r_y_hi;
    assign zero       = r_zero;
    assign illegal_op = r_ill;
`ifdef ALU_SEQ_DIV_EN
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, random ops against an arithmetic model.
// Honours ALU_SEQ_DIV_EN the same way as the design.
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y, y_hi;
    logic             zero, div_by_zero, illegal_op;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .y_hi        (y_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on the op code values.
    function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] ey, output logic [31:0] ehi,
                                  output logic edbz, output logic eill, output int elat);
        logic [63:0] prod;
        ey = '0; ehi = '0; edbz = 1'b0; eill = 1'b0; elat = 1;
        case (mop)
            4'd0:  ey = ma & mb;
            4'd1:  ey = ma | mb;
            4'd2:  ey = ma + mb;
            4'd3:  ey = 32'($signed(ma) >>> mb[4:0]);
            4'd4:  ey = ma << mb[4:0];
            4'd5:  ey = ma >> mb[4:0];
            4'd6:  ey = ma - mb;
            4'd7:  ey = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            4'd8: begin
                prod = {32'd0, ma} * {32'd0, mb};
                ey = prod[31:0]; ehi = prod[63:32]; elat = WIDTH + 1;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd9: begin
                if (mb == 0) begin
                    ey = 32'hFFFF_FFFF; ehi = ma; edbz = 1'b1;
                end else begin
                    ey = ma / mb; ehi = ma % mb; elat = WIDTH + 1;
                end
            end
`endif
            4'd10: ey = ma ^ mb;
            4'd11: ey = ~(ma | mb);
            4'd12: ey = (ma < mb) ? 32'd1 : 32'd0;
            default: eill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] top, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int hold, input string tag);
        logic [31:0] ey, ehi, sy, shi;
        logic        edbz, eill;
        int          elat, lat, wait_n;
        bit          ready_seen;
        model(top, ta, tb_v, ey, ehi, edbz, eill, elat);
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1; wait_n++;
        end
        check({tag, " in_ready before"}, in_ready, 1);
        @(negedge clk);
        op = top; a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1; ready_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) ready_seen = 1;
        check({tag, " latency"}, lat, elat);
        check({tag, " in_ready busy"}, ready_seen, 0);
        check({tag, " y"}, y, ey);
        check({tag, " y_hi"}, y_hi, ehi);
        check({tag, " zero"}, zero, (ey == 0));
        check({tag, " div_by_zero"}, div_by_zero, edbz);
        check({tag, " illegal_op"}, illegal_op, eill);
        sy = y; shi = y_hi;
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check({tag, " held out_valid"}, out_valid, 1);
            check({tag, " held y"}, y, sy);
            check({tag, " held y_hi"}, y_hi, shi);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check({tag, " out_valid after handoff"}, out_valid, 0);
        check({tag, " in_ready after handoff"}, in_ready, 1);
    endtask

    initial begin
        bit          early;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset y", y, 0);
        check("reset y_hi", y_hi, 0);
        check("reset zero", zero, 0);
        check("reset div_by_zero", div_by_zero, 0);
        check("reset illegal_op", illegal_op, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", in_ready, 1);

        run_op(4'd2,  32'h7FFF_FFFF, 32'h1, 0, "ADD wrap");
        run_op(4'd6,  32'd5, 32'd5, 0, "SUB zero");
        run_op(4'd7,  32'hFFFF_FFFF, 32'h1, 0, "SLT");
        run_op(4'd12, 32'hFFFF_FFFF, 32'h1, 0, "SLTU");
        run_op(4'd3,  32'h8000_0000, 32'd24, 0, "SRA");
        run_op(4'd4,  32'h1, 32'h21, 0, "SLL");
        run_op(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MULU max");
        run_op(4'd9,  32'h100, 32'd7, 0, "DIVU");
        run_op(4'd9,  32'h1234_5678, 32'd0, 0, "DIVU by zero");
        run_op(4'd14, 32'hDEAD_BEEF, 32'h1, 0, "illegal");
        run_op(4'd2,  32'h1234, 32'h4321, 5, "ADD stall");
        run_op(4'd8,  32'hA5A5_0001, 32'h0003_0007, 3, "MULU stall");

        // Reset in the middle of a multiply must abort it without a result.
        @(negedge clk);
        op = 4'd8; a = 32'h0001_0001; b = 32'h0002_0002; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("mid-MULU reset out_valid", out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        early = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) early = 1;
        end
        check("aborted MULU no result", early, 0);
        check("in_ready after abort", in_ready, 1);
        check("y after abort", y, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(15, 0));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(3, 0) == 0) rb = (rop == 4'd9) ? 32'd0 : ra;
            if ($urandom_range(3, 0) == 0) rb = rb & 32'hFF;
            run_op(rop, ra, rb, $urandom_range(3, 0), $sformatf("rand%0d op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
